// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory read bus between the fetch unit (master) and instruction memory (slave).
// Requests use valid/ready; responses return in order with no backpressure.
interface instr_fetch_unit_if #(
    parameter int XLEN = 32
);
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_addr;
    logic            imem_rsp_valid;
    logic [31:0]     imem_rsp_data;

    modport master (
        output imem_req_valid, imem_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data
    );

    modport slave (
        input  imem_req_valid, imem_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: PC, credit-limited imem requests, instruction FIFO, redirect flush.
// Optional macro FETCH_MISALIGN_TRAP_EN adds a FAULT state for misaligned redirect targets.
module instr_fetch_unit #(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    instr_fetch_unit_if.master  imem,
    input  logic                pc_src,
    input  logic [XLEN-1:0]     branch_target,
    output logic                instr_valid,
    input  logic                instr_ready,
    output logic [31:0]         instr,
    output logic [XLEN-1:0]     instr_pc,
    output logic [6:0]          op,
    output logic [2:0]          funct3,
    output logic                funct7,
    output logic                instr_fault
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [CW-1:0]   DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [PW-1:0]   LAST_C  = PW'(FIFO_DEPTH - 1);
    localparam logic [XLEN-1:0] STEP    = XLEN'(4);

`ifdef FETCH_MISALIGN_TRAP_EN
    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_FLUSH, S_FAULT} state_e;
`else
    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_FLUSH} state_e;
`endif

    state_e                          state_q;
    logic [XLEN-1:0]                 pc_q, pc_d;
    logic [XLEN-1:0]                 rsp_pc_q, rsp_pc_d;
    logic [CW-1:0]                   inflight_q, inflight_d;
    logic [CW-1:0]                   stale_q, stale_d;
    logic [CW-1:0]                   count_q, count_d;
    logic [PW-1:0]                   rd_q, rd_d;
    logic [PW-1:0]                   wr_q, wr_d;
    logic [FIFO_DEPTH-1:0][31:0]     data_q, data_d;
    logic [FIFO_DEPTH-1:0][XLEN-1:0] ipc_q, ipc_d;

    logic            accept, rsp, rsp_live, push, pop;
    logic [XLEN-1:0] tgt;
    logic [CW:0]     used;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_C) ? '0 : p + PW'(1);
    endfunction

`ifdef FETCH_MISALIGN_TRAP_EN
    logic tgt_bad;
    logic fault_q;
    assign tgt         = branch_target;
    assign tgt_bad     = branch_target[1:0] != 2'b00;
    assign instr_fault = fault_q;
`else
    assign tgt         = branch_target & ~XLEN'(3);
    assign instr_fault = 1'b0;
`endif

    assign rsp      = imem.imem_rsp_valid;
    assign rsp_live = rsp && (stale_q == '0);
    assign accept   = imem.imem_req_valid && imem.imem_req_ready;
    assign pop      = instr_valid && instr_ready && !pc_src;
    assign push     = rsp_live && !pc_src;

    // A slot freed by this cycle's pop is reusable immediately; this keeps a
    // two-entry buffer streaming at one instruction per cycle.
    assign used = {1'b0, inflight_q} + {1'b0, count_q} - {{CW{1'b0}}, pop};

    assign imem.imem_req_valid = (state_q == S_FETCH) && (stale_q == '0) &&
                                 (used < {1'b0, DEPTH_C});
    assign imem.imem_addr      = pc_q;

    assign instr_valid = count_q != '0;
    assign instr       = data_q[rd_q];
    assign instr_pc    = ipc_q[rd_q];
    assign op          = instr[6:0];
    assign funct3      = instr[14:12];
    assign funct7      = instr[30];

    always_comb begin
        pc_d       = pc_q;
        rsp_pc_d   = rsp_pc_q;
        inflight_d = inflight_q;
        stale_d    = stale_q;
        count_d    = count_q;
        rd_d       = rd_q;
        wr_d       = wr_q;
        data_d     = data_q;
        ipc_d      = ipc_q;
        if (pc_src) begin
            // Everything already in flight, including a request accepted right now,
            // will come back as stale and must be swallowed.
            pc_d       = tgt;
            rsp_pc_d   = tgt;
            count_d    = '0;
            rd_d       = '0;
            wr_d       = '0;
            inflight_d = '0;
            stale_d    = stale_q + inflight_q + CW'(accept) - CW'(rsp);
        end else begin
            if (accept) pc_d = pc_q + STEP;
            inflight_d = inflight_q + CW'(accept) - CW'(rsp_live);
            if (rsp && !rsp_live) stale_d = stale_q - CW'(1);
            if (push) begin
                data_d[wr_q] = imem.imem_rsp_data;
                ipc_d[wr_q]  = rsp_pc_q;
                wr_d         = ptr_inc(wr_q);
                rsp_pc_d     = rsp_pc_q + STEP;
            end
            if (pop) rd_d = ptr_inc(rd_q);
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            inflight_q <= '0;
            stale_q    <= '0;
            count_q    <= '0;
            rd_q       <= '0;
            wr_q       <= '0;
            data_q     <= '0;
            ipc_q      <= '0;
        end else begin
            pc_q       <= pc_d;
            rsp_pc_q   <= rsp_pc_d;
            inflight_q <= inflight_d;
            stale_q    <= stale_d;
            count_q    <= count_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            data_q     <= data_d;
            ipc_q      <= ipc_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
`ifdef FETCH_MISALIGN_TRAP_EN
            fault_q <= 1'b0;
`endif
        end else begin
`ifdef FETCH_MISALIGN_TRAP_EN
            if (pc_src) fault_q <= tgt_bad;
            if (pc_src && tgt_bad) begin
                state_q <= S_FAULT;
            end else
`endif
            if (pc_src) begin
                state_q <= (stale_d != '0) ? S_FLUSH : S_FETCH;
            end else begin
                case (state_q)
                    S_IDLE:  state_q <= S_FETCH;
                    S_FLUSH: if (stale_d == '0) state_q <= S_FETCH;
                    default: state_q <= state_q;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized bench for instr_fetch_unit: in-order latency memory model plus an
// instruction-stream scoreboard (expected PC sequence, redirect epochs).
module tb_instr_fetch_unit;
    localparam int XLEN  = 32;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pc_src = 1'b0;
    logic [31:0] branch_target = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr, instr_pc;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic        funct7, instr_fault;

    instr_fetch_unit_if #(.XLEN(XLEN)) imem ();

    instr_fetch_unit #(.XLEN(XLEN), .RESET_PC(32'h0), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .imem(imem),
        .pc_src(pc_src), .branch_target(branch_target),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .instr_pc(instr_pc), .op(op), .funct3(funct3),
        .funct7(funct7), .instr_fault(instr_fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
        int          ep;
    } mreq_t;

    mreq_t       mq[$];
    logic [31:0] acc_log[$];
    int          total = 0, passed = 0;
    int          cyc = 0, lat = 1, acc_count = 0, pops = 0, epoch = 0;
    bit          rnd_ready = 0, pend_acc = 0, flush_chk = 0;
    logic [31:0] pend_addr;
    int          pend_ep;
    logic [31:0] exp_pc = '0, req_exp = '0;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    // memory: accepts sampled at negedge, responses presented after the edge
    initial begin
        imem.imem_req_ready = 1'b1;
        imem.imem_rsp_valid = 1'b0;
        imem.imem_rsp_data  = '0;
        forever begin
            @(posedge clk); #1;
            cyc++;
            if (!rst_n) begin
                mq.delete();
                pend_acc = 0;
                imem.imem_rsp_valid = 1'b0;
                imem.imem_req_ready = 1'b1;
                continue;
            end
            if (imem.imem_rsp_valid && mq.size() > 0) void'(mq.pop_front());
            if (pend_acc) begin
                mq.push_back('{addr: pend_addr, due: cyc + lat - 1, ep: pend_ep});
                acc_log.push_back(pend_addr);
                acc_count++;
                pend_acc = 0;
            end
            if (mq.size() > 0 && mq[0].due <= cyc) begin
                imem.imem_rsp_valid = 1'b1;
                imem.imem_rsp_data  = memf(mq[0].addr);
            end else begin
                imem.imem_rsp_valid = 1'b0;
            end
            imem.imem_req_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // scoreboard: request addresses, no issue while stale, delivered stream
    initial begin
        bit          stale;
        logic [31:0] w;
        forever begin
            @(negedge clk);
            if (!rst_n) continue;
            if (flush_chk) begin
                total++;
                if (instr_valid !== 1'b0)
                    $display("FAIL flush_valid: instr_valid=%0b expected 0", instr_valid);
                else passed++;
                flush_chk = 0;
            end
            if (imem.imem_req_valid) begin
                stale = 0;
                foreach (mq[i]) if (mq[i].ep != epoch) stale = 1;
                total++;
                if (stale) $display("FAIL issue_while_stale: req_valid=1 expected 0");
                else passed++;
                if (imem.imem_req_ready) begin
                    total++;
                    if (imem.imem_addr !== req_exp)
                        $display("FAIL req_addr: got %h expected %h", imem.imem_addr, req_exp);
                    else passed++;
                    req_exp   = req_exp + 32'd4;
                    pend_acc  = 1;
                    pend_addr = imem.imem_addr;
                    pend_ep   = epoch;
                end
            end
            if (pc_src) begin
                epoch++;
                exp_pc    = branch_target & ~32'h3;
                req_exp   = exp_pc;
                flush_chk = 1;
            end else if (instr_valid && instr_ready) begin
                w = memf(exp_pc);
                total++;
                if (instr_pc !== exp_pc || instr !== w)
                    $display("FAIL pop_stream: pc=%h instr=%h expected pc=%h instr=%h",
                             instr_pc, instr, exp_pc, w);
                else passed++;
                total++;
                if (op !== w[6:0] || funct3 !== w[14:12] || funct7 !== w[30])
                    $display("FAIL decode_fields: op=%h f3=%h f7=%b expected %h %h %b",
                             op, funct3, funct7, w[6:0], w[14:12], w[30]);
                else passed++;
                exp_pc = exp_pc + 32'd4;
                pops++;
            end
        end
    end

    task automatic clear_model();
        exp_pc = '0; req_exp = '0; flush_chk = 0; epoch = 0;
        acc_count = 0; pops = 0; pend_acc = 0;
        acc_log.delete(); mq.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0; pc_src = 1'b0; instr_ready = 1'b0; rnd_ready = 0; lat = 1;
        repeat (2) @(posedge clk);
        #1 clear_model();
        rst_n = 1'b1;
    endtask

    task automatic redirect(input logic [31:0] t);
        @(posedge clk); #1;
        pc_src = 1'b1; branch_target = t;
        @(posedge clk); #1;
        pc_src = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        instr_ready = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk); #2 rst_n = 1'b0; #1;
        total++;
        if (imem.imem_req_valid !== 1'b0 || instr_valid !== 1'b0 || instr_fault !== 1'b0)
            $display("FAIL reset_ctrl: req_valid=%0b instr_valid=%0b fault=%0b expected 0 0 0",
                     imem.imem_req_valid, instr_valid, instr_fault);
        else passed++;
        total++;
        if (imem.imem_addr !== 32'h0 || instr !== 32'h0 || instr_pc !== 32'h0 ||
            op !== 7'h0 || funct3 !== 3'h0 || funct7 !== 1'b0)
            $display("FAIL reset_data: addr=%h instr=%h pc=%h expected all 0",
                     imem.imem_addr, instr, instr_pc);
        else passed++;
        repeat (2) @(posedge clk);
        #1 clear_model();
        rst_n = 1'b1;
        @(negedge clk); #1;
        total++;
        if (imem.imem_req_valid !== 1'b0)
            $display("FAIL idle_cycle: req_valid=%0b expected 0", imem.imem_req_valid);
        else passed++;
        @(negedge clk); #1;
        total++;
        if (imem.imem_req_valid !== 1'b1 || imem.imem_addr !== 32'h0)
            $display("FAIL first_req: valid=%0b addr=%h expected 1 00000000",
                     imem.imem_req_valid, imem.imem_addr);
        else passed++;
    endtask

    task automatic test_stream();
        int acc_c = -1, vld_c = -1, p0;
        do_reset();
        instr_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk); #1;
            if (acc_c < 0 && imem.imem_req_valid && imem.imem_req_ready) acc_c = c;
            if (vld_c < 0 && instr_valid) vld_c = c;
        end
        total++;
        if (acc_c < 0 || vld_c < 0 || vld_c - acc_c != 2)
            $display("FAIL first_latency: accept@%0d valid@%0d expected gap 2", acc_c, vld_c);
        else passed++;
        p0 = pops;
        repeat (10) @(negedge clk);
        #1;
        total++;
        if (pops - p0 != 10) $display("FAIL throughput: got %0d pops expected 10", pops - p0);
        else passed++;
        total++;
        if (acc_log.size() < 3 || acc_log[0] !== 32'h0 || acc_log[1] !== 32'h4 || acc_log[2] !== 32'h8)
            $display("FAIL stream_addrs: first addrs not 0,4,8 (count %0d)", acc_log.size());
        else passed++;
    endtask

    task automatic test_stall();
        int n;
        do_reset();
        repeat (6) @(negedge clk);
        #1;
        total++;
        if (acc_count != 2 || imem.imem_req_valid !== 1'b0 || instr_valid !== 1'b1 || instr_pc !== 32'h0)
            $display("FAIL stall_full: accepts=%0d req_valid=%0b instr_valid=%0b pc=%h expected 2 0 1 0",
                     acc_count, imem.imem_req_valid, instr_valid, instr_pc);
        else passed++;
        @(posedge clk); #1 instr_ready = 1'b1;
        n = 0;
        while (pops < 3 && n < 20) begin @(negedge clk); #1; n++; end
        total++;
        if (pops < 3) $display("FAIL stall_resume: got %0d pops expected >=3", pops);
        else passed++;
    endtask

    task automatic test_redirect_inflight();
        int n = 0;
        do_reset();
        lat = 3;
        instr_ready = 1'b1;
        while (acc_count < 2 && n < 20) begin @(posedge clk); #2; n++; end
        total++;
        if (acc_count != 2) $display("FAIL inflight_setup: accepts=%0d expected 2", acc_count);
        else passed++;
        pc_src = 1'b1; branch_target = 32'h100;
        @(posedge clk); #1 pc_src = 1'b0;
        n = 0;
        while (!instr_valid && n < 40) begin @(negedge clk); #1; n++; end
        total++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h100 || instr !== memf(32'h100))
            $display("FAIL redirect_head: valid=%0b pc=%h instr=%h expected 1 00000100 %h",
                     instr_valid, instr_pc, instr, memf(32'h100));
        else passed++;
        total++;
        if (acc_log.size() < 3 || acc_log[2] !== 32'h100)
            $display("FAIL redirect_req: third accept not 00000100 (count %0d)", acc_log.size());
        else passed++;
    endtask

    task automatic test_redirect_pop();
        int n = 0;
        do_reset();
        repeat (6) @(negedge clk);
        @(posedge clk); #1;
        pc_src = 1'b1; branch_target = 32'h40; instr_ready = 1'b1;
        @(posedge clk); #1 pc_src = 1'b0;
        #1;
        total++;
        if (instr_valid !== 1'b0 || imem.imem_addr !== 32'h40)
            $display("FAIL redirect_pop: valid=%0b addr=%h expected 0 00000040",
                     instr_valid, imem.imem_addr);
        else passed++;
        while (!instr_valid && n < 20) begin @(negedge clk); #1; n++; end
        total++;
        if (instr_pc !== 32'h40) $display("FAIL redirect_pop_head: pc=%h expected 00000040", instr_pc);
        else passed++;
    endtask

    task automatic test_wrap();
        int n0, n = 0;
        do_reset();
        instr_ready = 1'b1;
        repeat (3) @(posedge clk);
        redirect(32'hFFFF_FFF8);
        n0 = acc_log.size();
        while (acc_log.size() < n0 + 3 && n < 30) begin @(posedge clk); #2; n++; end
        total++;
        if (acc_log.size() < n0 + 3 || acc_log[n0] !== 32'hFFFF_FFF8 ||
            acc_log[n0+1] !== 32'hFFFF_FFFC || acc_log[n0+2] !== 32'h0)
            $display("FAIL pc_wrap: addrs after redirect not FFFFFFF8,FFFFFFFC,0 (count %0d)",
                     acc_log.size() - n0);
        else passed++;
        repeat (6) @(posedge clk);
    endtask

    task automatic test_misalign();
        int n0, n = 0;
        bit issued = 0;
        do_reset();
        instr_ready = 1'b1;
        repeat (4) @(posedge clk);
        redirect(32'h102);
`ifdef FETCH_MISALIGN_TRAP_EN
        total++;
        if (instr_fault !== 1'b1 || instr_valid !== 1'b0)
            $display("FAIL fault_set: fault=%0b valid=%0b expected 1 0", instr_fault, instr_valid);
        else passed++;
        repeat (6) begin @(negedge clk); if (imem.imem_req_valid) issued = 1; end
        total++;
        if (issued) $display("FAIL fault_no_issue: req_valid=1 expected 0");
        else passed++;
        redirect(32'h200);
        total++;
        if (instr_fault !== 1'b0) $display("FAIL fault_clear: fault=%0b expected 0", instr_fault);
        else passed++;
        n0 = acc_log.size();
        while (acc_log.size() <= n0 && n < 20) begin @(posedge clk); #2; n++; end
        total++;
        if (acc_log.size() <= n0 || acc_log[n0] !== 32'h200)
            $display("FAIL fault_resume: next accept not 00000200");
        else passed++;
`else
        total++;
        if (instr_fault !== 1'b0) $display("FAIL fault_tied: fault=%0b expected 0", instr_fault);
        else passed++;
        n0 = acc_log.size();
        while (acc_log.size() <= n0 && n < 20) begin @(posedge clk); #2; n++; end
        total++;
        if (acc_log.size() <= n0 || acc_log[n0] !== 32'h100)
            $display("FAIL align_force: next accept not 00000100 (issued %0b)", issued);
        else passed++;
`endif
    endtask

    task automatic test_random();
        int p0;
        do_reset();
        rnd_ready = 1;
        for (int seg = 0; seg < 8; seg++) begin
            lat = $urandom_range(1, 4);
            for (int c = 0; c < 150; c++) begin
                @(posedge clk); #1;
                instr_ready = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 19) == 0) begin
                    pc_src = 1'b1;
`ifdef FETCH_MISALIGN_TRAP_EN
                    branch_target = $urandom() & ~32'h3;
`else
                    branch_target = $urandom();
`endif
                end else begin
                    pc_src = 1'b0;
                end
            end
        end
        @(posedge clk); #1;
        pc_src = 1'b0; instr_ready = 1'b1; rnd_ready = 0;
        p0 = pops;
        repeat (30) @(negedge clk);
        #1;
        total++;
        if (pops - p0 < 20) $display("FAIL random_drain: got %0d pops expected >=20", pops - p0);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect_inflight();
        test_redirect_pop();
        test_wrap();
        test_misalign();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
